// File: rtl/arb_pkg.sv
`default_nettype none
// ============================================================================
// Package : arb_pkg
// Brief   : Shared types, constants and helpers for the request/grant arbiter
//           path and its requester endpoints.
// Rev     : 1.0 - initial release
// ============================================================================
package arb_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        ACTIVE  = 2'd1,
        RELEASE = 2'd2
    } req_state_t;

    localparam int                    WAIT_CNT_W   = 8;
    localparam logic [WAIT_CNT_W-1:0] WAIT_CNT_MAX = '1;

    // A length field of zero stands for the largest burst, 2^len_w beats.
    function automatic logic [16:0] decode_len(input logic [15:0] len,
                                               input int unsigned len_w);
        logic [16:0] v;
        if (len == 16'd0) begin
            v = 17'd1 << len_w;
        end else begin
            v = {1'b0, len};
        end
        return v;
    endfunction

endpackage : arb_pkg
`default_nettype wire

// File: rtl/req_job_fifo.sv
`default_nettype none
// ============================================================================
// Module : req_job_fifo
// Brief  : Synchronous FIFO holding pending requester jobs; no fall-through.
// Rev    : 1.0 - initial release
// ============================================================================
module req_job_fifo #(
    parameter int WIDTH = 12,
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             i_push,
    input  logic [WIDTH-1:0] i_push_data,
    input  logic             i_pop,
    output logic [WIDTH-1:0] o_pop_data,
    output logic             o_full,
    output logic             o_empty
);

    localparam int c_AW = $clog2(DEPTH);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [c_AW:0]    r_wr_ptr;
    logic [c_AW:0]    r_rd_ptr;
    logic             w_do_push;
    logic             w_do_pop;

    assign w_do_push = i_push && !o_full;
    assign w_do_pop  = i_pop && !o_empty;

    // Pointers carry one extra wrap bit to tell full from empty.
    assign o_empty = (r_wr_ptr == r_rd_ptr);
    assign o_full  = (r_wr_ptr[c_AW] != r_rd_ptr[c_AW]) &&
                     (r_wr_ptr[c_AW-1:0] == r_rd_ptr[c_AW-1:0]);

    assign o_pop_data = r_mem[r_rd_ptr[c_AW-1:0]];

    always_ff @(posedge clk) begin
        if (reset) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
        end else begin
            if (w_do_push) begin
                r_wr_ptr <= r_wr_ptr + (c_AW+1)'(1);
            end
            if (w_do_pop) begin
                r_rd_ptr <= r_rd_ptr + (c_AW+1)'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (w_do_push) begin
            r_mem[r_wr_ptr[c_AW-1:0]] <= i_push_data;
        end
    end

endmodule : req_job_fifo
`default_nettype wire

// File: rtl/arb_requester.sv
`default_nettype none
// ============================================================================
// Module : arb_requester
// Brief  : Requester endpoint: queues burst jobs, requests the shared bus and
//          issues one beat per granted cycle, surviving mid-burst preemption.
// Rev    : 1.0 - initial release
// ============================================================================
module arb_requester
    import arb_pkg::*;
#(
    parameter int DATA_W     = 8,
    parameter int LEN_W      = 4,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  job_valid,
    output logic                  job_ready,
    input  logic [DATA_W-1:0]     job_data,
    input  logic [LEN_W-1:0]      job_len,
    output logic                  req,
    input  logic                  grant,
    output logic                  bus_valid,
    output logic [DATA_W-1:0]     bus_data,
    output logic                  bus_last,
    output logic [WAIT_CNT_W-1:0] wait_cnt
);

    localparam int c_JOB_W = DATA_W + LEN_W;

    logic                  w_fifo_full;
    logic                  w_fifo_empty;
    logic [c_JOB_W-1:0]    w_head;
    logic [DATA_W-1:0]     w_head_data;
    logic [LEN_W-1:0]      w_head_len;

    req_state_t            r_state;
    req_state_t            w_state_next;
    logic                  r_req;
    logic                  w_pop;
    logic                  w_beat;

    logic [DATA_W-1:0]     r_base;
    logic [LEN_W-1:0]      r_len;
    logic [LEN_W:0]        r_beat_cnt;
    logic [WAIT_CNT_W-1:0] r_wait_cnt;
    logic [LEN_W:0]        w_last_idx;
    logic                  w_at_last;

    assign job_ready = !w_fifo_full;

    req_job_fifo #(
        .WIDTH (c_JOB_W),
        .DEPTH (FIFO_DEPTH)
    ) u_job_fifo (
        .clk         (clk),
        .reset       (reset),
        .i_push      (job_valid && job_ready),
        .i_push_data ({job_data, job_len}),
        .i_pop       (w_pop),
        .o_pop_data  (w_head),
        .o_full      (w_fifo_full),
        .o_empty     (w_fifo_empty)
    );

    assign {w_head_data, w_head_len} = w_head;

    // beat_cnt is one bit wider than len so a 2^LEN_W burst never wraps.
    assign w_last_idx = (LEN_W+1)'(decode_len(16'(r_len), LEN_W) - 17'd1);
    assign w_at_last  = (r_beat_cnt == w_last_idx);

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= IDLE;
            r_req   <= 1'b0;
        end else begin
            r_state <= w_state_next;
            r_req   <= (w_state_next == ACTIVE);
        end
    end

    always_comb begin
        w_state_next = r_state;
        w_pop        = 1'b0;
        w_beat       = 1'b0;
        bus_valid    = 1'b0;
        bus_last     = 1'b0;
        bus_data     = '0;
        case (r_state)
            IDLE: begin
                if (!w_fifo_empty) begin
                    w_pop        = 1'b1;
                    w_state_next = ACTIVE;
                end
            end
            ACTIVE: begin
                w_beat    = grant;
                bus_valid = grant;
                bus_data  = r_base + DATA_W'(r_beat_cnt);
                bus_last  = grant && w_at_last;
                if (grant && w_at_last) begin
                    w_state_next = RELEASE;
                end
            end
            // One dead cycle swallows the grant still in flight from the arbiter.
            RELEASE: begin
                w_state_next = IDLE;
            end
            default: begin
                w_state_next = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_base     <= '0;
            r_len      <= '0;
            r_beat_cnt <= '0;
            r_wait_cnt <= '0;
        end else if (w_pop) begin
            r_base     <= w_head_data;
            r_len      <= w_head_len;
            r_beat_cnt <= '0;
            r_wait_cnt <= '0;
        end else if (r_state == ACTIVE) begin
            if (w_beat) begin
                r_beat_cnt <= r_beat_cnt + (LEN_W+1)'(1);
            end else if (r_wait_cnt != WAIT_CNT_MAX) begin
                r_wait_cnt <= r_wait_cnt + WAIT_CNT_W'(1);
            end
        end
    end

    assign req      = r_req;
    assign wait_cnt = r_wait_cnt;

endmodule : arb_requester
`default_nettype wire
